// File: rtl/psum_axis_packer_if.sv
// psum_axis_packer_if
//   AXI4-Stream channel carrying packed partial-sum words.
//   tvalid : beat valid (master -> slave)
//   tdata  : DATA_WIDTH-bit beat payload (master -> slave)
//   tlast  : last beat of a packet (master -> slave)
//   tready : sink ready (slave -> master)
interface psum_axis_packer_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/psum_axis_packer.sv
// psum_axis_packer
//   Packs pairs of 32-bit running sums from the byte-sum MAC into 64-bit
//   words, buffers them in a show-ahead FIFO with registered outputs and
//   emits them as an AXI4-Stream packet stream (TLAST every BURST_LEN beats
//   or when flushed).
//
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   in_valid/data : running-sum sample stream, no backpressure
//   flush         : single-cycle pulse closing the current packet
//   m_axis        : AXIS master (tvalid/tdata/tlast/tready)
//   overflow      : sticky, a word was dropped on a full FIFO
//   beat_count    : completed AXIS handshakes, wraps
//   drop_count    : dropped words, wraps
//
// Build option:
//   PSUM_AXIS_PACKER_DROP_CNT_EN : when defined, drop_count counts dropped
//   words; otherwise drop_count is tied to 0.
module psum_axis_packer #(
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int BURST_LEN       = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  input  logic [31:0]               in_data,
  input  logic                      flush,
  psum_axis_packer_if.master        m_axis,
  output logic                      overflow,
  output logic [31:0]               beat_count,
  output logic [31:0]               drop_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PTR_W = FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int IDX_W = 16;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

  generate
    if (DATA_WIDTH != 64) begin : g_bad_width
      $error("psum_axis_packer: DATA_WIDTH must be 64");
    end
  endgenerate

  logic                  pend_q, pend_d;
  logic [31:0]           low_q, low_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [DATA_WIDTH:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           beat_q, beat_d;

  logic                  push, push_last, do_push, drop, pop, full;
  logic [DATA_WIDTH-1:0] push_word;
  logic [CNT_W-1:0]      cnt_after_pop;

  // Packing: the sample is applied first, then flush acts on the result.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    pend_d    = pend_q;
    low_d     = low_q;
    if (in_valid) begin
      if (pend_q) begin
        push      = 1'b1;
        push_word = {in_data, low_q};
        push_last = (idx_q == IDX_LAST) || flush;
        pend_d    = 1'b0;
      end else begin
        low_d  = in_data;
        pend_d = 1'b1;
      end
    end
    if (flush && !(in_valid && pend_q)) begin
      if (pend_d) begin
        push      = 1'b1;
        push_word = {32'h0, low_d};
        push_last = 1'b1;
        pend_d    = 1'b0;
      end else if (idx_q != '0) begin
        push      = 1'b1;
        push_word = '0;
        push_last = 1'b1;
      end
    end
  end

  // FIFO; a pop in the same cycle frees the slot for a push.
  always_comb begin
    pop           = tvalid_q && m_axis.tready;
    full          = (cnt_q == CNT_W'(DEPTH)) && !pop;
    do_push       = push && !full;
    drop          = push && full;
    cnt_after_pop = cnt_q - CNT_W'(pop);
    cnt_d         = cnt_after_pop + CNT_W'(do_push);
    rd_d          = rd_q + PTR_W'(pop);
    wr_d          = wr_q + PTR_W'(do_push);
    mem_d         = mem_q;
    if (do_push) mem_d[wr_q] = {push_last, push_word};

    idx_d = idx_q;
    if (do_push) idx_d = push_last ? '0 : idx_q + 1'b1;

    // Output register holds the next head; a push into an otherwise empty
    // FIFO bypasses the array so it is visible on the following cycle.
    tvalid_d = (cnt_d != '0);
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (cnt_d != '0) begin
      if (cnt_after_pop == '0) {tlast_d, tdata_d} = {push_last, push_word};
      else                     {tlast_d, tdata_d} = mem_q[rd_d];
    end

    overflow_d = overflow_q || drop;
    beat_d     = beat_q + 32'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q     <= 1'b0;
      low_q      <= '0;
      idx_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      low_q      <= low_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      overflow_q <= overflow_d;
      beat_q     <= beat_d;
    end
  end

  // Storage needs no reset; pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef PSUM_AXIS_PACKER_DROP_CNT_EN
  logic [31:0] drop_q, drop_d;
  always_comb drop_d = drop_q + 32'(drop);
  always_ff @(posedge clk) begin
    if (!rstn) drop_q <= '0;
    else       drop_q <= drop_d;
  end
  assign drop_count = drop_q;
`else
  assign drop_count = 32'h0;
`endif

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign overflow      = overflow_q;
  assign beat_count    = beat_q;

endmodule

// File: tb/tb_psum_axis_packer.sv
// tb_psum_axis_packer
//   Directed bench for psum_axis_packer built with BURST_LEN=4, depth 16.
module tb_psum_axis_packer;
  logic        clk = 1'b0;
  logic        rstn, in_valid, flush;
  logic [31:0] in_data;
  logic        overflow;
  logic [31:0] beat_count, drop_count;

  always #5 clk = ~clk;

  psum_axis_packer_if #(.DATA_WIDTH(64)) axis ();

  psum_axis_packer #(
    .DATA_WIDTH(64), .FIFO_DEPTH_LOG2(4), .BURST_LEN(4)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .m_axis(axis.master), .overflow(overflow),
    .beat_count(beat_count), .drop_count(drop_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] q[$];

  // Record every completed handshake as {tlast, tdata}.
  always @(negedge clk)
    if (rstn && axis.tvalid && axis.tready) q.push_back({axis.tlast, axis.tdata});

`ifdef PSUM_AXIS_PACKER_DROP_CNT_EN
  localparam logic [31:0] EXP_DROPS = 32'd4;
`else
  localparam logic [31:0] EXP_DROPS = 32'd0;
`endif

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] v);
    in_valid = 1'b1; in_data = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; in_data = '0; axis.tready = 1'b0;
    idle(2);
    rstn = 1'b1;
    q.delete();
  endtask

  function automatic logic [64:0] beat(input int i, input logic last);
    logic [31:0] hi, lo;
    hi = 32'(2*i + 2);
    lo = 32'(2*i + 1);
    return {last, hi, lo};
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
    n_cmp++; if (axis.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", axis.tlast); end
    n_cmp++; if (axis.tdata !== 64'h0) begin n_err++; $display("FAIL reset_tdata got %h want 0", axis.tdata); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (beat_count !== 32'h0) begin n_err++; $display("FAIL reset_beat_count got %0d want 0", beat_count); end
    n_cmp++; if (drop_count !== 32'h0) begin n_err++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
  endtask

  task automatic test_pack();
    do_reset();
    axis.tready = 1'b1;
    in_valid = 1'b1; in_data = 32'd1;
    tick();
    n_cmp++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL pack_tvalid_half got %b want 0", axis.tvalid); end
    in_data = 32'd2;
    tick();
    n_cmp++; if ({axis.tvalid, axis.tdata} !== {1'b1, 64'h00000002_00000001})
      begin n_err++; $display("FAIL pack_latency got v=%b d=%h want v=1 d=0000000200000001", axis.tvalid, axis.tdata); end
    in_data = 32'd3;
    tick();
    in_data = 32'd4;
    tick();
    in_valid = 1'b0;
    idle(4);
    n_cmp++; if (q.size() !== 2) begin n_err++; $display("FAIL pack_beats got %0d want 2", q.size()); end
    else begin
      n_cmp++; if (q[0] !== {1'b0, 64'h00000002_00000001}) begin n_err++; $display("FAIL pack_beat0 got %h want 00000000200000001", q[0]); end
      n_cmp++; if (q[1] !== {1'b0, 64'h00000004_00000003}) begin n_err++; $display("FAIL pack_beat1 got %h want 00000000400000003", q[1]); end
    end
    n_cmp++; if (beat_count !== 32'd2) begin n_err++; $display("FAIL pack_beat_count got %0d want 2", beat_count); end
  endtask

  task automatic test_burst();
    do_reset();
    axis.tready = 1'b1;
    for (int k = 0; k < 16; k++) send(32'(k + 1));
    idle(5);
    n_cmp++; if (q.size() !== 8) begin n_err++; $display("FAIL burst_beats got %0d want 8", q.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_cmp++; if (q[i] !== beat(i, (i == 3) || (i == 7)))
        begin n_err++; $display("FAIL burst_beat%0d got %h want %h", i, q[i], beat(i, (i == 3) || (i == 7))); end
    end
    n_cmp++; if (beat_count !== 32'd8) begin n_err++; $display("FAIL burst_beat_count got %0d want 8", beat_count); end
  endtask

  task automatic test_flush();
    do_reset();
    axis.tready = 1'b1;
    send(32'd1); send(32'd2); send(32'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    idle(4);
    n_cmp++; if (q.size() !== 2) begin n_err++; $display("FAIL flush_beats got %0d want 2", q.size()); end
    else begin
      n_cmp++; if (q[0] !== {1'b0, 64'h00000002_00000001}) begin n_err++; $display("FAIL flush_beat0 got %h want 00000000200000001", q[0]); end
      n_cmp++; if (q[1] !== {1'b1, 64'h00000000_00000003}) begin n_err++; $display("FAIL flush_beat1 got %h want 10000000000000003", q[1]); end
    end
    flush = 1'b1; tick(); flush = 1'b0;
    idle(4);
    n_cmp++; if (q.size() !== 2) begin n_err++; $display("FAIL flush_noop got %0d beats want 2", q.size()); end
    n_cmp++; if (beat_count !== 32'd2) begin n_err++; $display("FAIL flush_beat_count got %0d want 2", beat_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    axis.tready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1; in_data = 32'(k + 1);
      tick();
      if (k >= 1) begin
        n_cmp++; if ({axis.tvalid, axis.tdata} !== {1'b1, 64'h00000002_00000001})
          begin n_err++; $display("FAIL ovf_frozen k=%0d got v=%b d=%h want v=1 d=0000000200000001", k, axis.tvalid, axis.tdata); end
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (drop_count !== EXP_DROPS) begin n_err++; $display("FAIL ovf_drop_count got %0d want %0d", drop_count, EXP_DROPS); end
    axis.tready = 1'b1;
    idle(20);
    n_cmp++; if (q.size() !== 16) begin n_err++; $display("FAIL ovf_drain got %0d want 16", q.size()); end
    else for (int i = 0; i < 16; i++) begin
      n_cmp++; if (q[i] !== beat(i, (i % 4) == 3))
        begin n_err++; $display("FAIL ovf_beat%0d got %h want %h", i, q[i], beat(i, (i % 4) == 3)); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    n_cmp++; if (beat_count !== 32'd16) begin n_err++; $display("FAIL ovf_beat_count got %0d want 16", beat_count); end
  endtask

  task automatic test_full_no_drop();
    do_reset();
    axis.tready = 1'b0;
    for (int k = 0; k < 32; k++) send(32'(k + 1));
    send(32'd33);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pre_overflow got %b want 0", overflow); end
    axis.tready = 1'b1;
    send(32'd34);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pushpop_overflow got %b want 0", overflow); end
    idle(20);
    n_cmp++; if (q.size() !== 17) begin n_err++; $display("FAIL full_drain got %0d want 17", q.size()); end
    else begin
      n_cmp++; if (q[16] !== {1'b0, 32'd34, 32'd33}) begin n_err++; $display("FAIL full_last_word got %h want 00000002200000021", q[16]); end
      n_cmp++; if (q[15] !== beat(15, 1'b1)) begin n_err++; $display("FAIL full_word15 got %h want %h", q[15], beat(15, 1'b1)); end
    end
    n_cmp++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL full_drop_count got %0d want 0", drop_count); end
    n_cmp++; if (beat_count !== 32'd17) begin n_err++; $display("FAIL full_beat_count got %0d want 17", beat_count); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s [8];
    do_reset();
    axis.tready = 1'b1;
    for (int k = 0; k < 4; k++) send(32'(k + 1));
    idle(3);
    n_cmp++; if (beat_count !== 32'd2) begin n_err++; $display("FAIL rmid_pre_beat_count got %0d want 2", beat_count); end
    axis.tready = 1'b0;
    for (int k = 4; k < 15; k++) send(32'(k + 1));
    rstn = 1'b0;
    tick();
    n_cmp++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL rmid_tvalid got %b want 0", axis.tvalid); end
    n_cmp++; if (axis.tdata !== 64'h0) begin n_err++; $display("FAIL rmid_tdata got %h want 0", axis.tdata); end
    n_cmp++; if (beat_count !== 32'd0) begin n_err++; $display("FAIL rmid_beat_count got %0d want 0", beat_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rmid_overflow got %b want 0", overflow); end
    n_cmp++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL rmid_drop_count got %0d want 0", drop_count); end
    rstn = 1'b1;
    axis.tready = 1'b1;
    q.delete();
    for (int k = 0; k < 8; k++) begin
      s[k] = 32'hA5A5_0000 + 32'(k);
      send(s[k]);
    end
    idle(5);
    n_cmp++; if (q.size() !== 4) begin n_err++; $display("FAIL rmid_beats got %0d want 4", q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (q[i] !== {(i == 3), s[2*i+1], s[2*i]})
        begin n_err++; $display("FAIL rmid_beat%0d got %h want %h", i, q[i], {(i == 3), s[2*i+1], s[2*i]}); end
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_burst();
    test_flush();
    test_overflow();
    test_full_no_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_axis_packer.md
Name: psum_axis_packer

Overview:
- Downstream stage of the byte-sum MAC in the DDR bandwidth-test path.
- Accepts the MAC's 32-bit running-sum stream. That stream is valid-only and has no backpressure.
- Packs pairs of sums into 64-bit words and buffers them in a FIFO.
- Emits an AXI4-Stream master with TLAST every BURST_LEN beats, ready for the S2MM DMA write-back to DDR.

Parameters:
- DATA_WIDTH, 64: output beat width; fixed at 2x32. Any other value is a synthesis error.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2^FIFO_DEPTH_LOG2 words.
- BURST_LEN, 16: output beats per packet; TLAST is on beat BURST_LEN-1. Legal range 1..2^16.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- in_valid  input  1  running-sum sample valid; no ready
- in_data  input  32  running-sum sample (signed, passed through unmodified)
- flush  input  1  single-cycle pulse; closes the current packet
- m_axis_tvalid  output  1  AXIS valid
- m_axis_tdata  output  64  AXIS data
- m_axis_tlast  output  1  AXIS last
- m_axis_tready  input  1  AXIS ready
- overflow  output  1  sticky: a word was dropped because the FIFO was full
- beat_count  output  32  count of completed AXIS handshakes (tvalid && tready), wraps
- drop_count  output  32  count of dropped words (optional feature)

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
  - overflow=0, beat_count=0, drop_count=0
  - FIFO empty, half-word pending flag=0, packet word index=0
- Packing:
  - First sample of a pair is latched into bits [31:0] and the pending flag is set.
  - Second sample goes into [63:32]. On the same cycle the word {second, first} is pushed and the pending flag clears.
- TLAST is computed at push time and stored in the FIFO alongside the data:
  - last = (word index == BURST_LEN-1) or flush-forced.
  - Word index increments on each successful push and resets to 0 after a last word.
- Latency: the word pushed on cycle N shows m_axis_tvalid=1 on cycle N+1 at the earliest, provided the FIFO was empty. The FIFO is show-ahead with registered outputs.
- AXIS rules:
  - tvalid, tdata and tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - Back-to-back beats run at one per cycle when tready stays high.
- Flush, when the pulse arrives:
  - Half word pending: push {32'h0, low} with last=1.
  - No half word pending and word index != 0: push 64'h0 with last=1.
  - No half word pending and word index == 0: no-op.
- Flush and in_valid in the same cycle:
  - The sample is processed first, then the flush is applied to the resulting state.
  - If the sample completes a word with index BURST_LEN-1, that word already carries last and the flush becomes a no-op.
  - If the sample completes a word below that index, the word is pushed with last=1.
- FIFO full with a push required:
  - The word is dropped and overflow sets to 1.
  - Word index does not advance and the pending flag still clears.
  - overflow clears only on reset.
- Full and empty boundaries:
  - A push and a pop in the same cycle on a full FIFO is NOT a drop. The pop frees the slot in the same cycle, so the FIFO reports full only when occupancy=depth and there is no pop.
  - A pop on an empty FIFO is impossible, since tvalid=0 then.
- Pointers: wrap modulo 2^FIFO_DEPTH_LOG2. Occupancy is a FIFO_DEPTH_LOG2+1 bit counter.
- Reset mid-packet: everything returns to reset values. The partial word and all FIFO contents are discarded. The downstream packet is left unterminated; the DMA is reset alongside.
- beat_count and drop_count wrap 2^32-1 -> 0.

Optional Feature:
- Macro: PSUM_AXIS_PACKER_DROP_CNT_EN
- Defined: drop_count increments by 1 on every dropped word.
- Undefined: the counter logic is absent and drop_count is tied to 0. overflow still operates.

Test Plan:
- Samples 1,2,3,4 on consecutive cycles, tready=1:
  - Beat 0: tdata=64'h00000002_00000001.
  - Beat 1: tdata=64'h00000004_00000003.
  - First tvalid is 1 cycle after the push.
- BURST_LEN=4, 16 samples, tready=1 -> 8 beats, tlast on beats 3 and 7 only; beat_count=8.
- 3 samples then flush -> beat 0 = {2,1} with last=0; beat 1 = {0,3} with last=1. A second flush is a no-op (no beat).
- tready=0 with 40 samples (20 words, depth 16):
  - overflow=1 and drop_count=4.
  - tdata stays frozen on beat 0 throughout.
  - tready=1 then drains exactly 16 beats, in order.
- FIFO full, tready=1 and a new word completes in the same cycle -> no drop, overflow stays 0.
- rstn=0 asserted mid-packet with 5 words queued -> next cycle tvalid=0 and all counters 0. The next sample pair produces beat tdata={s1,s0} with index restarted at 0.
